// File: rtl/sseg_display_arbiter_if.sv
// Client-side bundle of the display arbiter: requests, patterns and the grant back.
interface sseg_display_arbiter_if;
  logic [2:0]  req;
  logic [31:0] pat0;
  logic [31:0] pat1;
  logic [31:0] pat2;
  logic [2:0]  gnt;
  logic        busy;

  modport master (output req, pat0, pat1, pat2, input gnt, busy);
  modport slave  (input req, pat0, pat1, pat2, output gnt, busy);
endinterface

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum dwell
// per grant; owns the digit scan counter and the registered anode/segment pins.
//   state | meaning
//   IDLE  | no client owns the display, pins blanked
//   GRANT | client in gnt owns the display, dwell counted in frames
module sseg_display_arbiter #(
  parameter int N     = 18,
  parameter int DWELL = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sseg_display_arbiter_if.slave bus,
  output logic [3:0]           an,
  output logic [7:0]           sseg
);
  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    q;
  logic [2:0]      gnt, gnt_nxt, others, pick_idle, pick_grant;
  logic [1:0]      last, last_nxt, cur, d;
  logic [DW_W-1:0] dw, dw_nxt;
  logic            frame_tick, expired;
  logic [31:0]     pat;
  logic [3:0]      an_nxt;
  logic [7:0]      sseg_nxt;

  // First requester strictly after client 'from', wrapping 2 -> 0.
  function automatic logic [2:0] rr_after(input logic [2:0] r, input logic [1:0] from);
    logic [2:0] pick;
    pick = 3'b000;
    case (from)
      2'd0:    if (r[1]) pick = 3'b010; else if (r[2]) pick = 3'b100; else if (r[0]) pick = 3'b001;
      2'd1:    if (r[2]) pick = 3'b100; else if (r[0]) pick = 3'b001; else if (r[1]) pick = 3'b010;
      default: if (r[0]) pick = 3'b001; else if (r[1]) pick = 3'b010; else if (r[2]) pick = 3'b100;
    endcase
    return pick;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  assign frame_tick = &q;
  assign expired    = (dw == DW_MAX);
  assign d          = q[N-1:N-2];
  assign cur        = onehot_idx(gnt);
  assign others     = bus.req & ~gnt;
  assign pick_idle  = rr_after(bus.req, last);
  assign pick_grant = rr_after(others, cur);
  assign bus.gnt    = gnt;
  assign bus.busy   = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd2;
      dw    <= '0;
      an    <= 4'hF;
      sseg  <= 8'hFF;
    end else begin
      q     <= q + 1'b1;
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      dw    <= dw_nxt;
      an    <= an_nxt;
      sseg  <= sseg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    dw_nxt    = dw;
    case (state)
      IDLE: begin
        dw_nxt = '0;
        if (|bus.req) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_idle;
          last_nxt  = onehot_idx(pick_idle);
        end
      end
      GRANT: begin
        // Release takes precedence over expiry; both hand over without an IDLE cycle.
        if (!(|(bus.req & gnt)) || (expired && |others)) begin
          dw_nxt = '0;
          if (|others) begin
            gnt_nxt  = pick_grant;
            last_nxt = onehot_idx(pick_grant);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (frame_tick && !expired) begin
          dw_nxt = dw + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    an_nxt   = 4'hF;
    sseg_nxt = 8'hFF;
    case (gnt)
      3'b001:  pat = bus.pat0;
      3'b010:  pat = bus.pat1;
      3'b100:  pat = bus.pat2;
      default: pat = 32'hFFFF_FFFF;
    endcase
    if (|gnt) begin
      an_nxt   = ~(4'b0001 << d);
      sseg_nxt = pat[{d, 3'b000} +: 8];
    end
  end
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Bench for sseg_display_arbiter with N=3, DWELL=2: vector table, directed
// corner sequences and a randomized run against a cycle-level reference model.
module tb_sseg_display_arbiter;
  localparam int N     = 3;
  localparam int DWELL = 2;
  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [7:0] sseg;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;

  sseg_display_arbiter_if bus ();

  sseg_display_arbiter #(.N(N), .DWELL(DWELL)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .an   (an),
    .sseg (sseg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner as an integer (-1 = nobody), dwell as frames seen.
  int         m_q, m_owner, m_last, m_frames, m_nx;
  logic [3:0] m_an;
  logic [7:0] m_sseg;

  function automatic int rr_pick(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++)
      if (r[(start + k) % 3]) return (start + k) % 3;
    return -1;
  endfunction

  function automatic int model_next(input int own, input int lst, input int frames, input logic [2:0] r);
    logic [2:0] oth;
    if (own < 0) return rr_pick(r, (lst + 1) % 3);
    oth = r & ~(3'b001 << own);
    if (!r[own]) return rr_pick(oth, (own + 1) % 3);
    if (frames == DWELL && oth != 3'b000) return rr_pick(oth, (own + 1) % 3);
    return own;
  endfunction

  function automatic logic [7:0] pat_byte(input int o, input int dg);
    logic [31:0] p;
    case (o)
      0:       p = bus.pat0;
      1:       p = bus.pat1;
      default: p = bus.pat2;
    endcase
    return 8'(p >> (8 * dg));
  endfunction

  always_comb m_nx = model_next(m_owner, m_last, m_frames, bus.req);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= 0;
      m_owner  <= -1;
      m_last   <= 2;
      m_frames <= 0;
      m_an     <= 4'hF;
      m_sseg   <= 8'hFF;
    end else begin
      m_q      <= (m_q + 1) % FRAME;
      m_owner  <= m_nx;
      if (m_nx >= 0 && m_nx != m_owner) m_last <= m_nx;
      if (m_nx < 0 || m_nx != m_owner) m_frames <= 0;
      else if (m_q == FRAME - 1 && m_frames < DWELL) m_frames <= m_frames + 1;
      m_an     <= (m_owner < 0) ? 4'hF : 4'hF ^ (4'b0001 << (m_q / (FRAME / 4)));
      m_sseg   <= (m_owner < 0) ? 8'hFF : pat_byte(m_owner, m_q / (FRAME / 4));
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_gnt", bus.gnt, (m_owner < 0) ? 3'b000 : 3'b001 << m_owner);
      check("model_busy", bus.busy, m_owner >= 0);
      check("model_an", an, m_an);
      check("model_sseg", sseg, m_sseg);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_gnt;
    logic [7:0] exp_sseg;
  } vec_t;

  vec_t        vecs[8];
  logic [3:0]  an_t[4];
  logic [7:0]  sg_t[4];
  logic [2:0]  segq[$];
  int          lenq[$];
  int          cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b001, 3'b001, 8'h44};
    vecs[1] = '{3'b010, 3'b010, 8'h88};
    vecs[2] = '{3'b100, 3'b100, 8'hCC};
    vecs[3] = '{3'b011, 3'b001, 8'h44};
    vecs[4] = '{3'b110, 3'b010, 8'h88};
    vecs[5] = '{3'b101, 3'b001, 8'h44};
    vecs[6] = '{3'b111, 3'b001, 8'h44};
    vecs[7] = '{3'b000, 3'b000, 8'hFF};
    an_t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_t = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};

    bus.req  = 3'b000;
    bus.pat0 = 32'h1122_3344;
    bus.pat1 = 32'h5566_7788;
    bus.pat2 = 32'h99AA_BBCC;
    rst = 1'b1;

    // Reset state, then idle after release
    step(10);
    check("rst_gnt", bus.gnt, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_an", an, 4'hF);
    check("rst_sseg", sseg, 8'hFF);
    rst = 1'b0;
    chk_en = 1'b1;
    step(5);
    check("idle_gnt", bus.gnt, 3'b000);
    check("idle_an", an, 4'hF);
    check("idle_sseg", sseg, 8'hFF);

    // First arbitration after reset, from the vector table
    for (int i = 0; i < 8; i++) begin
      bus.req = 3'b000;
      do_reset();
      bus.req = vecs[i].req;
      step(1);
      check($sformatf("vec%0d_gnt", i), bus.gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_gnt != 3'b000);
      step(1);
      check($sformatf("vec%0d_an", i), an, (vecs[i].exp_gnt != 3'b000) ? 4'b1110 : 4'b1111);
      check($sformatf("vec%0d_sseg", i), sseg, vecs[i].exp_sseg);
    end

    // Single client: scan sequence, grant held
    bus.req = 3'b000;
    bus.pat1 = 32'hC0F9_A4B0;
    do_reset();
    bus.req = 3'b010;
    step(1);
    check("single_gnt", bus.gnt, 3'b010);
    for (int k = 2; k <= 51; k++) begin
      step(1);
      check("single_hold", bus.gnt, 3'b010);
      check("single_an", an, an_t[((k - 1) % FRAME) / 2]);
      check("single_sseg", sseg, sg_t[((k - 1) % FRAME) / 2]);
    end

    // Contention: two frames of dwell each way
    bus.req = 3'b000;
    do_reset();
    bus.req = 3'b011;
    step(1);
    check("cont_first", bus.gnt, 3'b001);
    cnt = 0;
    while (bus.gnt == 3'b001 && cnt < 100) begin cnt++; step(1); end
    check("cont_dwell0", cnt, 16);
    check("cont_switch", bus.gnt, 3'b010);
    cnt = 0;
    while (bus.gnt == 3'b010 && cnt < 100) begin cnt++; step(1); end
    check("cont_dwell1", cnt, 16);
    check("cont_back", bus.gnt, 3'b001);

    // Early release hands over directly
    bus.req = 3'b000;
    do_reset();
    bus.req = 3'b101;
    step(1);
    check("early_first", bus.gnt, 3'b001);
    step(3);
    bus.req = 3'b100;
    step(1);
    check("early_gnt", bus.gnt, 3'b100);
    check("early_old_sseg", sseg, 8'h22);
    step(1);
    check("early_an", an, 4'b1011);
    check("early_sseg", sseg, 8'hAA);

    // Fairness over 12 frames
    bus.req = 3'b000;
    do_reset();
    bus.req = 3'b111;
    segq.delete();
    lenq.delete();
    for (int k = 1; k <= 96; k++) begin
      step(1);
      if (segq.size() == 0 || bus.gnt != segq[$]) begin
        segq.push_back(bus.gnt);
        lenq.push_back(1);
      end else begin
        lenq[$] = lenq[$] + 1;
      end
    end
    check("fair_segments", segq.size(), 6);
    for (int i = 0; i < 6 && i < segq.size(); i++) begin
      check($sformatf("fair_gnt%0d", i), segq[i], 3'b001 << (i % 3));
      check($sformatf("fair_len%0d", i), lenq[i], 16);
    end

    // Asynchronous reset between clock edges
    bus.req = 3'b000;
    do_reset();
    bus.req = 3'b100;
    step(4);
    check("async_pre", bus.gnt, 3'b100);
    #1;
    rst = 1'b1;
    #3;
    check("async_gnt", bus.gnt, 3'b000);
    check("async_busy", bus.busy, 1'b0);
    check("async_an", an, 4'hF);
    check("async_sseg", sseg, 8'hFF);
    rst = 1'b0;
    bus.req = 3'b111;
    step(1);
    check("async_regrant", bus.gnt, 3'b001);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(7) == 0) bus.req = 3'($urandom_range(7));
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(2))
          0:       bus.pat0 = $urandom;
          1:       bus.pat1 = $urandom;
          default: bus.pat2 = $urandom;
        endcase
      end
      if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else begin
        step(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
